// File: rtl/reg_scoreboard.sv
// Register scoreboard: tracks in-flight writes per architectural register,
// raises a decode stall on RAW hazards or a saturated destination, and
// exposes registered busy/inflight/err status.
module reg_scoreboard #(
  parameter int unsigned MAXPEND = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       issue_valid,
  input  logic [2:0] issue_src1sel,
  input  logic       issue_src1use,
  input  logic [2:0] issue_src2sel,
  input  logic       issue_src2use,
  input  logic [2:0] issue_dstsel,
  input  logic       issue_write,
  input  logic       wb_write,
  input  logic [2:0] wb_regsel,
  input  logic       flush,
  output logic       stall,
  output logic [7:0] busy,
  output logic [3:0] inflight,
  output logic       err
);

  localparam int unsigned NREG = 8;
  localparam int unsigned CW   = 2;
  localparam int unsigned SW   = 5;

  logic [CW-1:0]   r_cnt [NREG];
  logic [NREG-1:0] r_busy;
  logic [3:0]      r_inflight;
  logic            r_err;

  logic [CW-1:0]   w_cnt_nxt [NREG];
  logic [NREG-1:0] w_busy_nxt;
  logic [SW-1:0]   w_sum;
  logic            w_err_nxt;
  logic [NREG-1:0] w_inc;
  logic [NREG-1:0] w_dec;
  logic            w_hz1;
  logic            w_hz2;
  logic            w_full;
  logic            w_stall;
  logic            w_accept;
  logic [CW-1:0]   w_max;

  assign w_max = CW'(MAXPEND);

  // Hazard detection; a source with one pending write retiring this cycle is served by the RF bypass
  always_comb begin
    w_hz1    = issue_src1use && (r_cnt[issue_src1sel] != '0) &&
               !((r_cnt[issue_src1sel] == CW'(1)) && wb_write && (wb_regsel == issue_src1sel));
    w_hz2    = issue_src2use && (r_cnt[issue_src2sel] != '0) &&
               !((r_cnt[issue_src2sel] == CW'(1)) && wb_write && (wb_regsel == issue_src2sel));
    w_full   = issue_write && (r_cnt[issue_dstsel] == w_max) &&
               !(wb_write && (wb_regsel == issue_dstsel));
    w_stall  = rst && issue_valid && !flush && (w_hz1 || w_hz2 || w_full);
    w_accept = rst && issue_valid && !flush && !w_stall;
  end

  assign stall = w_stall;

  // Next-state counters, error flag and derived status
  always_comb begin
    w_err_nxt  = r_err;
    w_sum      = '0;
    w_busy_nxt = '0;
    w_inc      = '0;
    w_dec      = '0;
    for (int r = 0; r < NREG; r++) begin
      w_cnt_nxt[r] = r_cnt[r];
      w_inc[r]     = w_accept && issue_write && (issue_dstsel == 3'(r));
      w_dec[r]     = wb_write && (wb_regsel == 3'(r));
      if (w_dec[r] && (r_cnt[r] == '0)) begin
        w_err_nxt = 1'b1;
      end
      if (flush) begin
        w_cnt_nxt[r] = (w_dec[r] && (r_cnt[r] != '0)) ? CW'(1) : CW'(0);
      end else if (w_inc[r] && !w_dec[r]) begin
        if (r_cnt[r] != w_max) begin
          w_cnt_nxt[r] = r_cnt[r] + CW'(1);
        end
      end else if (w_dec[r] && !w_inc[r]) begin
        if (r_cnt[r] != '0) begin
          w_cnt_nxt[r] = r_cnt[r] - CW'(1);
        end
      end
      w_busy_nxt[r] = (w_cnt_nxt[r] != '0);
      w_sum         = w_sum + SW'(w_cnt_nxt[r]);
    end
  end

  // State and status registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int r = 0; r < NREG; r++) begin
        r_cnt[r] <= '0;
      end
      r_busy     <= '0;
      r_inflight <= '0;
      r_err      <= 1'b0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        r_cnt[r] <= w_cnt_nxt[r];
      end
      r_busy     <= w_busy_nxt;
      r_inflight <= 4'(w_sum);
      r_err      <= w_err_nxt;
    end
  end

  assign busy     = r_busy;
  assign inflight = r_inflight;
  assign err      = r_err;

endmodule
